// File: rtl/i4001_rom.sv
// Sixteen 128x16 storage banks sharing address and write data, each with a
// read-first registered output; read_id picks which bank's register drives out.
module i4001_rom (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [10:0] column_id,
   input  logic [3:0]  read_id,
   input  logic [15:0] in,
   input  logic [1:0]  mode,
   output logic [15:0] out
);

   localparam logic [1:0] MODE_READ  = 2'b00;
   localparam logic [1:0] MODE_WRITE = 2'b01;
   localparam logic [1:0] MODE_BCAST = 2'b10;

   logic [3:0]  bank_sel;
   logic [6:0]  word_addr;
   logic [15:0] we;
   logic [15:0] bank_dout [16];

   assign bank_sel  = column_id[10:7];
   assign word_addr = column_id[6:0];

   // Reserved mode falls into the default and writes nothing.
   always_comb begin
      we = '0;
      case (mode)
         MODE_READ:  we = '0;
         MODE_WRITE: we[bank_sel] = 1'b1;
         MODE_BCAST: we = '1;
         default:    we = '0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_bank
         logic [15:0] mem [128] = '{default: 16'h0000};
         logic [15:0] dout_d;
         logic [15:0] dout_q;

         assign dout_d = mem[word_addr];

         // Writes are qualified by RST_N so an edge seen during reset stores nothing.
         always_ff @(posedge CLK) begin
            if (we[gi] && RST_N) begin
               mem[word_addr] <= in;
            end
         end

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               dout_q <= 16'h0000;
            end else begin
               dout_q <= dout_d;
            end
         end

         assign bank_dout[gi] = dout_q;
      end
   endgenerate

   assign out = bank_dout[read_id];

endmodule

// File: tb/tb_i4001_rom.sv
// Directed bench for i4001_rom: stimulus pushes expected words into a queue and
// a monitor process pops and compares them against out.
module tb_i4001_rom;

   logic        CLK;
   logic        RST_N;
   logic [10:0] column_id;
   logic [3:0]  read_id;
   logic [15:0] in;
   logic [1:0]  mode;
   logic [15:0] out;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } item_t;

   item_t sb[$];
   event  check_ev;
   int    tests = 0;
   int    fails = 0;

   i4001_rom dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .column_id (column_id),
      .read_id   (read_id),
      .in        (in),
      .mode      (mode),
      .out       (out)
   );

   initial CLK = 1'b0;
   always #50 CLK = ~CLK;

   initial begin
      forever begin
         @(check_ev);
         while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            tests++;
            if (out !== it.exp) begin
               fails++;
               $display("FAIL %s: out=%h required=%h", it.name, out, it.exp);
            end else begin
               $display("[TB] ok %s: out=%h", it.name, out);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic expect_out(input string nm, input logic [3:0] rid, input logic [15:0] exp);
      read_id = rid;
      #1;
      sb.push_back('{nm, exp});
      -> check_ev;
      #1;
   endtask

   task automatic cycle(input logic [1:0] m, input logic [3:0] bank, input logic [6:0] addr,
                        input logic [15:0] din);
      mode      = m;
      column_id = {bank, addr};
      in        = din;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N     = 1'b1;
      mode      = 2'b00;
      column_id = '0;
      in        = '0;
      read_id   = '0;
      #2;
      RST_N = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         expect_out($sformatf("reset_out_%0d", i), 4'(i), 16'h0000);
      end

      // Write attempted while reset is held must not land.
      cycle(2'b01, 4'd5, 7'd1, 16'hBEEF);
      RST_N = 1'b1;
      cycle(2'b00, 4'd5, 7'd1, 16'h0000);
      expect_out("rst_inhibit", 4'd5, 16'h0000);

      // Single-bank write.
      cycle(2'b01, 4'd3, 7'd5, 16'hA5A5);
      cycle(2'b00, 4'd3, 7'd5, 16'h0000);
      expect_out("single_b3", 4'd3, 16'hA5A5);
      expect_out("single_b4", 4'd4, 16'h0000);

      // Broadcast write at the top address.
      cycle(2'b10, 4'd0, 7'd127, 16'h1234);
      cycle(2'b00, 4'd0, 7'd127, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         expect_out($sformatf("bcast_b%0d", i), 4'(i), 16'h1234);
      end

      // Reserved mode writes nothing.
      cycle(2'b11, 4'd7, 7'd9, 16'hFFFF);
      cycle(2'b00, 4'd7, 7'd9, 16'h0000);
      expect_out("reserved_b7", 4'd7, 16'h0000);
      expect_out("reserved_b0", 4'd0, 16'h0000);

      // Read-first behaviour on a same-address write.
      cycle(2'b01, 4'd2, 7'd10, 16'h0001);
      cycle(2'b01, 4'd2, 7'd10, 16'h0002);
      expect_out("readfirst_old", 4'd2, 16'h0001);
      cycle(2'b00, 4'd2, 7'd10, 16'h0000);
      expect_out("readfirst_new", 4'd2, 16'h0002);

      // Highest bank, lowest address.
      cycle(2'b01, 4'd15, 7'd0, 16'h0F0F);
      cycle(2'b00, 4'd15, 7'd0, 16'h0000);
      expect_out("edge_b15", 4'd15, 16'h0F0F);
      expect_out("edge_b14", 4'd14, 16'h0000);

      // Asynchronous reset mid-operation clears outputs but keeps storage.
      RST_N = 1'b0;
      #1;
      expect_out("midrst_b15", 4'd15, 16'h0000);
      expect_out("midrst_b2", 4'd2, 16'h0000);
      RST_N = 1'b1;
      cycle(2'b00, 4'd3, 7'd5, 16'h0000);
      expect_out("postrst_b3", 4'd3, 16'hA5A5);
      cycle(2'b00, 4'd2, 7'd10, 16'h0000);
      expect_out("postrst_b2", 4'd2, 16'h0002);
      cycle(2'b00, 4'd0, 7'd127, 16'h0000);
      expect_out("postrst_b9", 4'd9, 16'h1234);

      #5;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i4001_rom.md
I4001_ROM -- requirements
Module: i4001_rom

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 column_id  input  11  [10:7] bank select (0-15); [6:0] word address within the bank (0-127).
REQ-005 read_id  input  4  selects which bank's registered word drives out.
REQ-006 in  input  16  write data.
REQ-007 mode  input  2  operation code: 00 read, 01 single-bank write, 10 broadcast write, 11 reserved.
REQ-008 out  output  16  registered read word of bank read_id.

Function
REQ-009 The block SHALL contain 16 independent storage banks, each 128 words x 16 bits (32768 bits total).
REQ-010 Every bank SHALL receive the same word address, column_id[6:0], and the same write data, in.
REQ-011 A write-enable decoder SHALL produce a 16-bit one-per-bank enable we[15:0] combinationally from column_id[10:7] and mode.
REQ-012 With mode 00, the decoder SHALL drive we = 0, so no write occurs.
REQ-013 With mode 01, the decoder SHALL drive we = one-hot with bit column_id[10:7] set, so only that bank is written.
REQ-014 With mode 10, the decoder SHALL drive we = 16'hFFFF, so all banks are written at address column_id[6:0].
REQ-015 With mode 11, the decoder SHALL drive we = 0, so no write occurs.
REQ-016 On each rising CLK edge with we[k]=1, bank k SHALL write in to word column_id[6:0].
REQ-017 Each bank SHALL have a 16-bit output register that loads the word at column_id[6:0] on every rising CLK edge, regardless of mode.
REQ-018 Read latency SHALL be 1 cycle from the address edge to the bank output register.
REQ-019 On a simultaneous write and read of the same bank and address, the output register SHALL capture the old (pre-write) data (read-first); the new data appears one edge later.
REQ-020 out SHALL equal the output register of bank read_id, selected combinationally with no added latency.
REQ-021 Changing read_id SHALL change out within the same cycle.
REQ-022 Address and bank select SHALL use plain binary indexing with no wrap-around logic; all 11-bit column_id values are valid.
REQ-023 All storage words SHALL initialise to 16'h0000 at power-up.

Reset
REQ-024 While RST_N=0, all 16 bank output registers SHALL clear to 16'h0000 immediately, independent of CLK, so out = 16'h0000.
REQ-025 While RST_N=0, all writes SHALL be inhibited.
REQ-026 Reset SHALL NOT clear storage array contents.
REQ-027 After RST_N rises, the first rising CLK edge SHALL resume normal reads and writes.
REQ-028 An RST_N assertion in the middle of a write cycle SHALL suppress that write.

Verification
REQ-029 Reset check: RST_N=0 -> out=16'h0000 for every read_id 0-15, with no clock edge required.
REQ-030 Single-bank write: mode=01, column_id={4'd3,7'd5}, in=16'hA5A5, one edge; then mode=00, same column_id, read_id=3, one edge -> out=16'hA5A5; read_id=4 -> out=16'h0000.
REQ-031 Broadcast write: mode=10, column_id={4'd0,7'd127}, in=16'h1234, one edge; then read address 127 -> out=16'h1234 for read_id 0 through 15.
REQ-032 Reserved mode: mode=11, column_id={4'd7,7'd9}, in=16'hFFFF, one edge; then read bank 7 address 9 -> out=16'h0000.
REQ-033 Read-first: bank 2 address 10 holds 16'h0001; mode=01 writing 16'h0002 there -> out after that edge=16'h0001; after the next edge=16'h0002.
REQ-034 Reset mid-operation: data written, then RST_N pulsed low -> out=16'h0000 during reset; after release, a read of the same address returns the written data.
